// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the LEGv8 shared memory-port arbiter.
// Requester IDs double as the last-grant pointer encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_align_check.sv
// Natural-alignment check for a single access: byte always legal,
// half/word/double need their low address bits clear.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = |addr_lo[1:0];
      SZ_D:    misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data paths onto one fixed-latency synchronous
// memory port and returns completion through a req/ack handshake.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with stable operands and holds both
  // until its ack; ack is a single-cycle pulse carrying rdata and err.
  // A req still high in the cycle after ack is treated as a new request.

  state_t            state_q, state_d;
  req_id_t           last_q, gnt_q, sel_id;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_misaligned;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [DATA_W-1:0] rdata_ext;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    sel_id    = REQ_IF;
    any_req   = if_req | dm_req;
    if (if_req && dm_req) begin
      sel_id = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (dm_req) begin
      sel_id = REQ_DM;
    end
    sel_addr  = if_addr;
    sel_size  = SZ_W;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (sel_id == REQ_DM) begin
      sel_addr  = dm_addr;
      sel_size  = dm_size;
      sel_we    = dm_we;
      sel_wdata = dm_wdata;
    end
  end

  mem_align_check u_align (
    .size       (sel_size),
    .addr_lo    (sel_addr[2:0]),
    .misaligned (sel_misaligned)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = sel_misaligned ? RESP : ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Loads are zero-extended by size; the memory already right-justifies.
  always_comb begin
    rdata_ext = '0;
    case (lat_size)
      SZ_B:    rdata_ext[7:0]  = mem_rdata[7:0];
      SZ_H:    rdata_ext[15:0] = mem_rdata[15:0];
      SZ_W:    rdata_ext[31:0] = mem_rdata[31:0];
      default: rdata_ext       = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q     <= REQ_IF;
      gnt_q      <= REQ_IF;
      lat_we     <= 1'b0;
      lat_size   <= SZ_B;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= SZ_B;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= sel_id;
            lat_we   <= sel_we;
            lat_size <= sel_size;
            err_q    <= sel_misaligned;
            // A rejected access must leave the memory bus untouched.
            if (!sel_misaligned) begin
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_size  <= sel_size;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          cnt_q  <= CNT_W'(LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (!lat_we) begin
              if (gnt_q == REQ_IF) if_rdata_q <= mem_rdata[31:0];
              else                 dm_rdata_q <= rdata_ext;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          last_q <= gnt_q;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign if_ack    = (state_q == RESP) && (gnt_q == REQ_IF);
  assign dm_ack    = (state_q == RESP) && (gnt_q == REQ_DM);
  assign if_err    = if_ack & err_q;
  assign dm_err    = dm_ack & err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a LAT=1 instance for arbitration/store/alignment cases and
// a LAT=4 instance for long-latency and reset-during-wait cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_req4, dm_req, dm_req4, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [1:0]  dm_size;

  logic        if_ack, if_err, dm_ack, dm_err, mem_en, mem_we;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size, dbg_state;

  logic        if_ack4, if_err4, dm_ack4, dm_err4, mem_en4, mem_we4;
  logic [31:0] if_rdata4;
  logic [63:0] dm_rdata4, mem_addr4, mem_wdata4;
  logic [1:0]  mem_size4, dbg_state4;

  int          n_vec = 0;
  int          n_err = 0;
  int          acks;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(1)) u_dut (
    .clock(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(4)) u_dut4 (
    .clock(clk), .reset(rst_n),
    .if_req(if_req4), .if_addr(if_addr), .if_ack(if_ack4), .if_rdata(if_rdata4), .if_err(if_err4),
    .dm_req(dm_req4), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack4), .dm_rdata(dm_rdata4), .dm_err(dm_err4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_size(mem_size4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata), .dbg_state(dbg_state4)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 0; if_req4 = 0; dm_req = 0; dm_req4 = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; dm_size = 2'b00;
    step(); step();
    chk("rst_if_ack", 64'(if_ack), 64'd0);
    chk("rst_dm_ack", 64'(dm_ack), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_dm_rdata", dm_rdata, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    step();

    // Single fetch, LAT=1
    if_req = 1; if_addr = 64'h100; mem_rdata = 64'hFFFF_FFFF_8B02_0020;
    exp_q.push_back(64'h8B02_0020);
    chk("f1_en_t0", 64'(mem_en), 64'd0);
    step();
    chk("f1_en_t1", 64'(mem_en), 64'd1);
    chk("f1_addr", mem_addr, 64'h100);
    chk("f1_size", 64'(mem_size), 64'd2);
    chk("f1_we", 64'(mem_we), 64'd0);
    step();
    chk("f1_en_t2", 64'(mem_en), 64'd0);
    chk("f1_ack_t2", 64'(if_ack), 64'd0);
    step();
    chk("f1_ack_t3", 64'(if_ack), 64'd1);
    chk("f1_rdata", 64'(if_rdata), exp_q.pop_front());
    chk("f1_err", 64'(if_err), 64'd0);
    chk("f1_dm_ack", 64'(dm_ack), 64'd0);
    if_req = 0;
    step();
    chk("f1_ack_t4", 64'(if_ack), 64'd0);
    chk("f1_idle", 64'(dbg_state), 64'd0);

    // Tie from reset release: DM, then IF, then DM
    rst_n = 0; if_req = 1; if_addr = 64'h40;
    dm_req = 1; dm_we = 0; dm_size = 2'b11; dm_addr = 64'h300;
    mem_rdata = 64'h1122_3344_5566_7788;
    exp_q.push_back(64'h1122_3344_5566_7788);
    step();
    rst_n = 1;
    step();
    chk("tie1_en", 64'(mem_en), 64'd1);
    chk("tie1_addr", mem_addr, 64'h300);
    step(); step();
    chk("tie1_dm_ack", 64'(dm_ack), 64'd1);
    chk("tie1_dm_rdata", dm_rdata, exp_q.pop_front());
    chk("tie1_if_ack", 64'(if_ack), 64'd0);
    dm_req = 0; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    chk("tie2_idle_en", 64'(mem_en), 64'd0);
    chk("tie2_idle", 64'(dbg_state), 64'd0);
    step();
    chk("tie2_en", 64'(mem_en), 64'd1);
    chk("tie2_addr", mem_addr, 64'h40);
    step(); step();
    chk("tie2_if_ack", 64'(if_ack), 64'd1);
    chk("tie2_if_rdata", 64'(if_rdata), 64'hCCCC_DDDD);
    chk("tie2_dm_ack", 64'(dm_ack), 64'd0);
    dm_req = 1; dm_size = 2'b00; dm_addr = 64'h310;
    step();
    chk("tie3_idle", 64'(dbg_state), 64'd0);
    step();
    chk("tie3_en", 64'(mem_en), 64'd1);
    chk("tie3_addr", mem_addr, 64'h310);
    chk("tie3_size", 64'(mem_size), 64'd0);
    step(); step();
    chk("tie3_dm_ack", 64'(dm_ack), 64'd1);
    chk("tie3_byte_zext", dm_rdata, 64'hDD);
    chk("tie3_if_ack", 64'(if_ack), 64'd0);
    if_req = 0; dm_req = 0;
    step();

    // Doubleword store
    dm_req = 1; dm_we = 1; dm_size = 2'b11; dm_addr = 64'h208; dm_wdata = 64'hDEAD_BEEF;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    chk("st_en", 64'(mem_en), 64'd1);
    chk("st_we", 64'(mem_we), 64'd1);
    chk("st_addr", mem_addr, 64'h208);
    chk("st_wdata", mem_wdata, 64'hDEAD_BEEF);
    step(); step();
    chk("st_ack", 64'(dm_ack), 64'd1);
    chk("st_err", 64'(dm_err), 64'd0);
    chk("st_rdata_hold", dm_rdata, 64'hDD);
    dm_req = 0; dm_we = 0;
    step();

    // Misaligned data word and fetch
    dm_req = 1; dm_size = 2'b10; dm_addr = 64'h202;
    step();
    chk("mis_dm_ack", 64'(dm_ack), 64'd1);
    chk("mis_dm_err", 64'(dm_err), 64'd1);
    chk("mis_dm_en", 64'(mem_en), 64'd0);
    chk("mis_dm_rdata", dm_rdata, 64'hDD);
    dm_req = 0;
    step();
    chk("mis_idle_en", 64'(mem_en), 64'd0);
    chk("mis_idle_ack", 64'(dm_ack), 64'd0);
    chk("mis_addr_hold", mem_addr, 64'h208);
    if_req = 1; if_addr = 64'h101;
    step();
    chk("mis_if_ack", 64'(if_ack), 64'd1);
    chk("mis_if_err", 64'(if_err), 64'd1);
    chk("mis_if_en", 64'(mem_en), 64'd0);
    chk("mis_if_rdata", 64'(if_rdata), 64'hCCCC_DDDD);
    if_req = 0;
    step();
    chk("mis_if_ack_end", 64'(if_ack), 64'd0);

    // LAT=4 load: only the WAIT count 0 sample is captured
    dm_we = 0; dm_size = 2'b11; dm_addr = 64'h400; dm_req4 = 1;
    mem_rdata = 64'hBAD0_0000_0000_0001;
    step();
    chk("l4_en", 64'(mem_en4), 64'd1);
    chk("l4_addr", mem_addr4, 64'h400);
    for (int k = 2; k <= 5; k++) begin
      mem_rdata = 64'hBAD0_0000_0000_0000 + 64'(k);
      step();
      chk("l4_no_early_ack", 64'(dm_ack4), 64'd0);
    end
    mem_rdata = 64'h0F0E_0D0C_0B0A_0908;
    step();
    chk("l4_ack", 64'(dm_ack4), 64'd1);
    chk("l4_rdata", dm_rdata4, 64'h0F0E_0D0C_0B0A_0908);
    dm_req4 = 0;
    step();
    chk("l4_ack_end", 64'(dm_ack4), 64'd0);

    // Reset during WAIT abandons the access
    dm_addr = 64'h408; dm_req4 = 1;
    step();
    chk("rw_en", 64'(mem_en4), 64'd1);
    step(); step();
    rst_n = 0;
    #1;
    chk("rw_en_rst", 64'(mem_en4), 64'd0);
    chk("rw_ack_rst", 64'(dm_ack4), 64'd0);
    chk("rw_rdata_rst", dm_rdata4, 64'd0);
    chk("rw_addr_rst", mem_addr4, 64'd0);
    chk("rw_state_rst", 64'(dbg_state4), 64'd0);
    dm_req4 = 0;
    step(); step();
    rst_n = 1;
    acks = 0;
    repeat (8) begin
      step();
      if (dm_ack4) acks++;
    end
    chk("rw_no_ack", 64'(acks), 64'd0);
    dm_addr = 64'h410; mem_rdata = 64'h77; dm_req4 = 1;
    step();
    chk("rw2_en", 64'(mem_en4), 64'd1);
    repeat (4) step();
    chk("rw2_no_early_ack", 64'(dm_ack4), 64'd0);
    step();
    chk("rw2_ack", 64'(dm_ack4), 64'd1);
    chk("rw2_rdata", dm_rdata4, 64'h77);
    dm_req4 = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared data/instruction memory port of the multi-cycle LEGv8 CPU. It arbitrates between the instruction-fetch path (IF state, word reads) and the data-memory path (LDUR/STUR, all sizes). It drives a fixed-latency synchronous memory and returns data and completion to the winning requester through a req/ack handshake. Misaligned accesses are rejected with an error flag and never reach memory.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..15
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; size is always word (2'b10)
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched instruction, valid while if_ack=1
- if_err  out  1  misaligned fetch, valid while if_ack=1
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data, right-justified
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  load data, zero-extended, valid while dm_ack=1
- dm_err  out  1  misaligned access, valid while dm_ack=1
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_size  out  2  access size
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, right-justified, valid LAT cycles after the mem_en cycle

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE, at least one req:
  - Only one req: grant it.
  - Both reqs: grant the requester not granted last. The last-grant pointer resets to IF, so DM wins the first tie.
  - The granted request's address, size, we and wdata are latched into registers at grant.
- Alignment rule: addr[0] must be 0 for half, addr[1:0] must be 0 for word, addr[2:0] must be 0 for double. Byte is always legal. Fetch is checked as word.
- Misaligned: IDLE→RESP with err=1. No mem_en is issued. rdata outputs hold their previous value.
- Aligned: IDLE→ACCESS with registered mem_en=1 and memory outputs driven from the latched request.
- ACCESS→WAIT: mem_en returns to 0 and the counter loads LAT-1.
- WAIT: count down. At count 0, capture mem_rdata into the granted requester's rdata register (if_rdata = mem_rdata[31:0]), then go to RESP.
  - Stores follow the same path and timing. rdata is not updated on a store.
- RESP: pulse the granted ack (plus err) for exactly one cycle. Update the last-grant pointer. Go to IDLE.
  - No new grant is made in RESP. This prevents re-granting a req that drops only after ack.
- Non-granted outputs stay 0. mem_addr, mem_size, mem_we and mem_wdata hold their values outside the mem_en cycle.
- Deasserting req or changing operands before ack is a protocol violation. Behaviour in that case is unspecified; no assertion is required.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE; all outputs, rdata registers and the counter go to 0; pointer goes to IF.
  - Any in-flight access is abandoned and no ack is produced.
  - Release is sampled on the next rising edge.
- Req in cycle t, aligned: mem_en high in t+1, mem_rdata sampled at the end of t+1+LAT, ack in t+2+LAT. Latency is LAT+2 cycles (3 for LAT=1).
- Req in cycle t, misaligned: ack+err in t+1.
- IDLE is re-entered in the cycle after ack. Back-to-back aligned throughput is one access per LAT+3 cycles.
- Req rising in the same cycle as the other requester's ack is sampled in the following IDLE cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ACCESS, WAIT, RESP)
  - size constants SZ_B/SZ_H/SZ_W/SZ_D
  - requester IDs REQ_IF/REQ_DM
- One combinational sub-module, `mem_align_check` (size, addr[2:0] → misaligned). It is instantiated once, on the pre-grant selected request.
- Counter width is 4 bits.

## Test plan
- Single fetch, LAT=1, if_addr=0x100, mem_rdata=0x8B020020 → mem_en in t+1 only, if_ack in t+3, if_rdata=0x8B020020, if_err=0.
- if_req and dm_req both high from reset release → DM granted first; IF granted in the IDLE cycle after dm_ack; third tie goes to DM.
- dm_we=1, dm_size=11, dm_addr=0x208, wdata=0xDEADBEEF → mem_we=1 and mem_addr=0x208 in the mem_en cycle; dm_ack after LAT+2 cycles; dm_rdata unchanged.
- dm_size=10, dm_addr=0x202 → dm_ack+dm_err in t+1, mem_en never asserted. Same for if_addr=0x101.
- LAT=4 load → ack 6 cycles after req; mem_rdata is sampled only at WAIT count 0, and earlier garbage is ignored.
- reset asserted during WAIT → all outputs 0 immediately; no ack after release; the next req is serviced with normal latency.
